uart_hex_loader: RTL and testbench

- Receive-side counterpart of the hex dump path: an 8N1 UART receiver plus an ASCII-hex parser.
- Accepts hex text on the serial RX pin and assembles digit pairs into bytes.
- Writes each byte to a memory/dispatcher write port at an auto-incrementing address.
- Used to load correlator coefficients/buffers from a host terminal at the same baud as the dump path.

---
 rtl/uart_hex_loader.sv | 205 ++++++++++++++++++++
 tb/tb_uart_hex_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_loader.sv
// 8N1 UART receiver feeding an ASCII-hex parser that writes assembled bytes
// to a memory/dispatcher port at an auto-incrementing address.
module uart_hex_loader #(
  parameter int unsigned clk_freq = 48000000,
  parameter int unsigned sym_rate = 1200,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fpga_rx,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  output logic          frame_err,
  output logic          bad_char,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  localparam int unsigned sym_cnt = clk_freq / sym_rate;
  localparam int unsigned SCW     = $clog2(sym_cnt);
  localparam logic [SCW-1:0] CNT_FULL = SCW'(sym_cnt - 1);
  localparam logic [SCW-1:0] CNT_HALF = SCW'(sym_cnt / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_e;

  rx_state_e      state_q, state_d;
  logic           rx_meta_q, rx_sync_q;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           frame_err_q, frame_err_d;
  logic           tick_c;

  logic           pend_q, pend_d;
  logic [3:0]     high_q, high_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           wr_en_q, wr_en_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]     wr_data_q, wr_data_d;
  logic           bad_char_q, bad_char_d;
  logic           is_hex_c;
  logic [3:0]     nib_c;

  // Two-flop synchronizer; idles high so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= fpga_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign tick_c = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_sync_q) state_d = S_START;
      S_START: if (tick_c) state_d = rx_sync_q ? S_IDLE : S_DATA;
      S_DATA:  if (tick_c && (bit_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (tick_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bit timing, shifting and frame result; the stop sample returns to IDLE
  // immediately so a back-to-back start edge is caught on the next cycle.
  always_comb begin
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_HALF;
        bit_d = 3'd0;
      end
      S_START: begin
        if (tick_c) cnt_d = CNT_FULL;
        else        cnt_d = cnt_q - SCW'(1);
      end
      S_DATA: begin
        if (tick_c) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          cnt_d   = CNT_FULL;
        end else begin
          cnt_d = cnt_q - SCW'(1);
        end
      end
      S_STOP: begin
        if (tick_c) begin
          if (rx_sync_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - SCW'(1);
        end
      end
      default: cnt_d = CNT_HALF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    is_hex_c = 1'b1;
    nib_c    = 4'd0;
    if ((rx_data_q >= 8'h30) && (rx_data_q <= 8'h39))      nib_c = 4'(rx_data_q - 8'h30);
    else if ((rx_data_q >= 8'h61) && (rx_data_q <= 8'h66)) nib_c = 4'(rx_data_q - 8'h57);
    else if ((rx_data_q >= 8'h41) && (rx_data_q <= 8'h46)) nib_c = 4'(rx_data_q - 8'h37);
    else                                                   is_hex_c = 1'b0;
  end

  // Parser: pairs nibbles into bytes, line ends rewind the address.
  always_comb begin
    pend_d     = pend_q;
    high_d     = high_q;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    bad_char_d = 1'b0;
    if (rx_valid_q) begin
      if (is_hex_c) begin
        if (pend_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {high_q, nib_c};
          pend_d    = 1'b0;
          addr_d    = addr_q + AW'(1);
        end else begin
          high_d = nib_c;
          pend_d = 1'b1;
        end
      end else if ((rx_data_q == 8'h0D) || (rx_data_q == 8'h0A)) begin
        addr_d = '0;
        pend_d = 1'b0;
      end else if ((rx_data_q != 8'h20) && (rx_data_q != 8'h09)) begin
        bad_char_d = 1'b1;
        pend_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      high_q     <= 4'd0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
      bad_char_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      high_q     <= high_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      bad_char_q <= bad_char_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign bad_char  = bad_char_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Bench for uart_hex_loader: serial stimulus into two instances (AW=8, AW=2)
// compared against a character-level reference model.
module tb_uart_hex_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fpga_rx = 1'b1;

  logic [7:0] rx_data;
  logic       rx_valid, frame_err, bad_char, wr_en8;
  logic [7:0] wr_addr8, wr_data8;
  logic [7:0] rx_data2;
  logic       rx_valid2, frame_err2, bad_char2, wr_en2;
  logic [1:0] wr_addr2;
  logic [7:0] wr_data2;

  always #5 clk = ~clk;

  uart_hex_loader #(.clk_freq(16), .sym_rate(1), .AW(8)) u_dut8 (
    .clk(clk), .rst(rst), .fpga_rx(fpga_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .bad_char(bad_char),
    .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8)
  );

  uart_hex_loader #(.clk_freq(16), .sym_rate(1), .AW(2)) u_dut2 (
    .clk(clk), .rst(rst), .fpga_rx(fpga_rx),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .frame_err(frame_err2), .bad_char(bad_char2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] obs_w8[$], exp_w8[$];
  logic [9:0]  obs_w2[$], exp_w2[$];
  logic [7:0]  obs_rx[$], exp_rx[$];
  int obs_fe = 0, exp_fe = 0, obs_bc = 0, exp_bc = 0, viol = 0;

  bit         m_pend = 1'b0;
  int         m_high = 0;
  int         m_addr = 0;
  logic [7:0] m_last = 8'd0;

  logic prev_rv = 1'b0, prev_fe = 1'b0, prev_bc = 1'b0, prev_we = 1'b0;

  // Observation away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en8)    obs_w8.push_back({wr_addr8, wr_data8});
      if (wr_en2)    obs_w2.push_back({wr_addr2, wr_data2});
      if (rx_valid)  obs_rx.push_back(rx_data);
      if (frame_err) obs_fe++;
      if (bad_char)  obs_bc++;
      if (wr_en8 && !prev_rv) viol++;
      if ((rx_valid && prev_rv) || (frame_err && prev_fe) ||
          (bad_char && prev_bc) || (wr_en8 && prev_we)) viol++;
    end
    prev_rv = rx_valid;
    prev_fe = frame_err;
    prev_bc = bad_char;
    prev_we = wr_en8;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_char(input logic [7:0] c);
    int nib;
    int v;
    nib = -1;
    exp_rx.push_back(c);
    m_last = c;
    if (c >= 8'h30 && c <= 8'h39)      nib = int'(c) - 48;
    else if (c >= 8'h61 && c <= 8'h66) nib = int'(c) - 87;
    else if (c >= 8'h41 && c <= 8'h46) nib = int'(c) - 55;
    if (nib >= 0) begin
      if (m_pend) begin
        v = m_high * 16 + nib;
        exp_w8.push_back({8'(m_addr % 256), 8'(v)});
        exp_w2.push_back({2'(m_addr % 4), 8'(v)});
        m_addr++;
        m_pend = 1'b0;
      end else begin
        m_high = nib;
        m_pend = 1'b1;
      end
    end else if (c == 8'h0A || c == 8'h0D) begin
      m_addr = 0;
      m_pend = 1'b0;
    end else if (c != 8'h20 && c != 8'h09) begin
      exp_bc++;
      m_pend = 1'b0;
    end
  endtask

  // One 8N1 frame; abort_at >= 0 pulses rst at that cycle and leaves the line idle.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int gap, input int abort_at);
    logic [9:0] fr;
    int cyc;
    fr  = {stop_ok, b, 1'b0};
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 16; k++) begin
        if (cyc == abort_at) begin
          fpga_rx = 1'b1;
          rst     = 1'b1;
          tick();
          rst     = 1'b0;
          m_pend  = 1'b0;
          m_addr  = 0;
          m_last  = 8'd0;
          return;
        end
        fpga_rx = fr[i];
        tick();
        cyc++;
      end
    end
    fpga_rx = 1'b1;
    repeat (gap) tick();
    if (stop_ok) model_char(b);
    else         exp_fe++;
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, gap, -1);
  endtask

  task automatic lit_w8(input string tag, input int idx, input logic [15:0] v);
    chk(tag, (idx < obs_w8.size()) ? 32'(obs_w8[idx]) : 32'hFFFF_FFFF, 32'(v));
  endtask

  task automatic lit_w2(input string tag, input int idx, input logic [9:0] v);
    chk(tag, (idx < obs_w2.size()) ? 32'(obs_w2[idx]) : 32'hFFFF_FFFF, 32'(v));
  endtask

  task automatic verify(input string tag);
    repeat (4) tick();
    chk({tag, "_nw8"}, 32'(obs_w8.size()), 32'(exp_w8.size()));
    for (int i = 0; i < exp_w8.size() && i < obs_w8.size(); i++)
      chk({tag, "_w8"}, 32'(obs_w8[i]), 32'(exp_w8[i]));
    chk({tag, "_nw2"}, 32'(obs_w2.size()), 32'(exp_w2.size()));
    for (int i = 0; i < exp_w2.size() && i < obs_w2.size(); i++)
      chk({tag, "_w2"}, 32'(obs_w2[i]), 32'(exp_w2[i]));
    chk({tag, "_nrx"}, 32'(obs_rx.size()), 32'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size() && i < obs_rx.size(); i++)
      chk({tag, "_rx"}, 32'(obs_rx[i]), 32'(exp_rx[i]));
    chk({tag, "_fe"}, 32'(obs_fe), 32'(exp_fe));
    chk({tag, "_bc"}, 32'(obs_bc), 32'(exp_bc));
    chk({tag, "_rxdata"}, 32'(rx_data), 32'(m_last));
    obs_w8.delete(); exp_w8.delete();
    obs_w2.delete(); exp_w2.delete();
    obs_rx.delete(); exp_rx.delete();
  endtask

  initial begin
    string alpha;
    int    r;
    logic [7:0] c;

    rst = 1'b1;
    fpga_rx = 1'b1;
    repeat (3) tick();
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_bad_char", 32'(bad_char), 32'h0);
    chk("rst_wr_en", 32'(wr_en8), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr8), 32'h0);
    chk("rst_wr_data", 32'(wr_data8), 32'h0);
    rst = 1'b0;
    repeat (5) tick();

    send_str("A5", 2);
    repeat (4) tick();
    lit_w8("a5_write", 0, 16'h00A5);
    verify("a5");

    send_str("\n01 02ff", 0);
    repeat (4) tick();
    lit_w8("b2b_w0", 0, 16'h0001);
    lit_w8("b2b_w1", 1, 16'h0102);
    lit_w8("b2b_w2", 2, 16'h02FF);
    verify("b2b");

    send_str("\n12\n34", 1);
    repeat (4) tick();
    lit_w8("lf_w0", 0, 16'h0012);
    lit_w8("lf_w1", 1, 16'h0034);
    verify("lf");

    send_str("\n1G23", 1);
    repeat (4) tick();
    lit_w8("bad_w0", 0, 16'h0023);
    verify("bad");

    send_byte(8'h41, 1'b0, 24, -1);
    verify("ferr");

    fpga_rx = 1'b0;
    repeat (4) tick();
    fpga_rx = 1'b1;
    repeat (40) tick();
    verify("glitch");

    send_str("\n0102030405", 0);
    repeat (4) tick();
    lit_w2("aw2_w0", 0, 10'h001);
    lit_w2("aw2_w3", 3, 10'h304);
    lit_w2("aw2_w4", 4, 10'h005);
    verify("aw2");

    send_str("\n7", 1);
    send_byte(8'h45, 1'b1, 0, 72);
    fpga_rx = 1'b1;
    repeat (30) tick();
    verify("midrst");
    send_str("7E", 1);
    repeat (4) tick();
    lit_w8("midrst_w0", 0, 16'h007E);
    verify("after_rst");

    alpha = "0123456789abcdefABCDEF \t\nxZ!";
    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(alpha.len(), 0));
      c = (r == alpha.len()) ? 8'h0D : alpha[r];
      send_byte(c, 1'b1, int'($urandom_range(3, 0)), -1);
    end
    verify("rand");

    chk("pulse_timing", 32'(viol), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
